// File: rtl/gfx_pkg.sv
// Shared fixed-point, FP32 and perspective-divide definitions for the geometry pipeline.
package gfx_pkg;

  localparam int unsigned FRAC_BITS  = 16;
  localparam logic [31:0] ONE_Q16    = 32'h0001_0000;
  localparam logic [31:0] Q_MAX      = 32'h7FFF_FFFF;

  localparam int unsigned EXP_BIAS   = 127;
  localparam int unsigned EXP_MAX    = 255;

  localparam int unsigned DIV_CYCLES = 48;
  localparam int unsigned DIV_W      = 48;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [2:0] {IDLE, CONVERT, CHECK, DIVIDE, MAP, DONE} pd_state_t;

  // One restoring-divider lane: remainder plus a shared dividend/quotient shift register.
  typedef struct packed {
    logic [31:0]      rem;
    logic [DIV_W-1:0] dq;
  } div_lane_t;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  function automatic div_lane_t div_step(input div_lane_t s, input logic [31:0] d);
    logic [32:0] trial;
    div_lane_t   r;
    trial = {s.rem, s.dq[DIV_W-1]};
    r.dq  = {s.dq[DIV_W-2:0], 1'b0};
    if (trial >= {1'b0, d}) begin
      r.rem   = 32'(trial - {1'b0, d});
      r.dq[0] = 1'b1;
    end else begin
      r.rem = trial[31:0];
    end
    return r;
  endfunction

  // Magnitude of a two's-complement Q16.16 value (inputs never reach -2^31).
  function automatic logic [31:0] q_abs(input logic [31:0] v);
    return v[31] ? 32'(-v) : v;
  endfunction

  // Saturate a 48-bit quotient to 31 bits and apply the sign.
  function automatic logic [31:0] q_sat_sign(input logic [DIV_W-1:0] q, input logic neg);
    logic [31:0] mag;
    mag = (|q[DIV_W-1:31]) ? Q_MAX : q[31:0];
    return neg ? 32'(-mag) : mag;
  endfunction

endpackage

// File: rtl/float_to_fixed.sv
// Combinational FP32 -> signed Q16.16, truncating, saturating to +/-0x7FFFFFFF.
// Ports: f (FP32 in), q_c (Q16.16 out), nan_c (input is NaN).
module float_to_fixed
  import gfx_pkg::*;
(
  input  logic [31:0] f,
  output logic [31:0] q_c,
  output logic        nan_c
);

  logic              sign;
  logic [7:0]        exp_f;
  logic [22:0]       frac;
  logic signed [9:0] e;
  logic [31:0]       mant;
  logic [31:0]       mag;
  logic              sat;

  always_comb begin
    sign  = f[31];
    exp_f = f[30:23];
    frac  = f[22:0];
    e     = signed'({2'b00, exp_f}) - signed'(10'(EXP_BIAS));
    mant  = {8'h00, 1'b1, frac};
    mag   = '0;
    sat   = 1'b0;
    nan_c = 1'b0;
    if (exp_f == 8'h00) begin
      mag = '0;
    end else if (exp_f == 8'(EXP_MAX)) begin
      sat   = 1'b1;
      nan_c = |frac;
    end else if (e >= 10'sd15) begin
      sat = 1'b1;
    end else if (e < -10'sd16) begin
      mag = '0;
    end else if (e >= 10'sd7) begin
      // {1,frac} is 1.23; Q16.16 needs a shift of e-7
      mag = mant << 5'(e - 10'sd7);
    end else begin
      mag = mant >> 5'(10'sd7 - e);
    end
    if (sat) mag = Q_MAX;
    q_c = sign ? 32'(-mag) : mag;
  end

endmodule

// File: rtl/perspective_divide.sv
// Clip-space FP32 vertex -> screen pixel + Q16.16 depth via sequential divide by w.
// Ports: clk_in, rst_in (sync, active-low), pos/valid_in (vertex in), ready_out (idle),
//        px_out/py_out/depth_out/clipped_out (result), valid_out (result strobe),
//        dropped_out (vertex offered while busy).
module perspective_divide
  import gfx_pkg::*;
#(
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned SCREEN_H = 180
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [3:0][31:0] pos,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [10:0]      px_out,
  output logic [9:0]       py_out,
  output logic [31:0]      depth_out,
  output logic             clipped_out,
  output logic             valid_out,
  output logic             dropped_out
);

  pd_state_t        state_q, state_d;
  logic [3:0][31:0] pos_q;
  logic [3:0][31:0] fix_c;
  logic [3:0]       nan_c;
  logic             unused_nan;
  logic [31:0]      ax_q, ay_q, az_q, w_q;
  logic             w_nan_q;
  logic             clip_w_q;
  div_lane_t        dx_q, dy_q, dz_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      ndc_x_q, ndc_y_q, ndc_z_q;

  logic             w_clip_c;
  logic             map_clip_c;
  logic [43:0]      px_prod_c, py_prod_c, px_raw_c, py_raw_c;
  logic [10:0]      px_c;
  logic [9:0]       py_c;

  for (genvar i = 0; i < 4; i++) begin : g_f2f
    float_to_fixed u_f2f (
      .f     (pos_q[i]),
      .q_c   (fix_c[i]),
      .nan_c (nan_c[i])
    );
  end

  // Only the w lane's NaN flag affects behaviour.
  assign unused_nan = ^nan_c[3:1];

  // State register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      ready_out <= 1'b1;
    end else begin
      state_q   <= state_d;
      ready_out <= (state_d == IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    w_clip_c = w_nan_q || ($signed(w_q) <= 32'sd0);
    case (state_q)
      IDLE:    if (valid_in) state_d = CONVERT;
      CONVERT: state_d = CHECK;
      CHECK:   state_d = w_clip_c ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = MAP;
      MAP:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NDC -> screen mapping, consumed in DONE.
  always_comb begin
    map_clip_c = clip_w_q || (q_abs(ndc_x_q) > ONE_Q16) || (q_abs(ndc_y_q) > ONE_Q16);
    px_prod_c  = 44'(32'(ndc_x_q + ONE_Q16)) * 44'(SCREEN_W);
    py_prod_c  = 44'(32'(ONE_Q16 - ndc_y_q)) * 44'(SCREEN_H);
    px_raw_c   = px_prod_c >> 17;
    py_raw_c   = py_prod_c >> 17;
    px_c       = (px_raw_c >= 44'(SCREEN_W)) ? 11'(SCREEN_W - 1) : px_raw_c[10:0];
    py_c       = (py_raw_c >= 44'(SCREEN_H)) ? 10'(SCREEN_H - 1) : py_raw_c[9:0];
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pos_q       <= '0;
      ax_q        <= '0;
      ay_q        <= '0;
      az_q        <= '0;
      w_q         <= '0;
      w_nan_q     <= 1'b0;
      clip_w_q    <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      dz_q        <= '0;
      cnt_q       <= '0;
      ndc_x_q     <= '0;
      ndc_y_q     <= '0;
      ndc_z_q     <= '0;
      px_out      <= '0;
      py_out      <= '0;
      depth_out   <= '0;
      clipped_out <= 1'b0;
      valid_out   <= 1'b0;
      dropped_out <= 1'b0;
    end else begin
      valid_out   <= 1'b0;
      dropped_out <= valid_in && (state_q != IDLE);
      case (state_q)
        IDLE: if (valid_in) pos_q <= pos;
        CONVERT: begin
          ax_q    <= fix_c[3];
          ay_q    <= fix_c[2];
          az_q    <= fix_c[1];
          w_q     <= fix_c[0];
          w_nan_q <= nan_c[0];
        end
        CHECK: begin
          clip_w_q <= w_clip_c;
          cnt_q    <= '0;
          dx_q     <= '{rem: '0, dq: {q_abs(ax_q), FRAC_BITS'(0)}};
          dy_q     <= '{rem: '0, dq: {q_abs(ay_q), FRAC_BITS'(0)}};
          dz_q     <= '{rem: '0, dq: {q_abs(az_q), FRAC_BITS'(0)}};
        end
        DIVIDE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          dx_q  <= div_step(dx_q, w_q);
          dy_q  <= div_step(dy_q, w_q);
          dz_q  <= div_step(dz_q, w_q);
        end
        MAP: begin
          // w > 0 here, so the quotient sign is the numerator sign
          ndc_x_q <= q_sat_sign(dx_q.dq, ax_q[31]);
          ndc_y_q <= q_sat_sign(dy_q.dq, ay_q[31]);
          ndc_z_q <= q_sat_sign(dz_q.dq, az_q[31]);
        end
        DONE: begin
          valid_out   <= 1'b1;
          clipped_out <= map_clip_c;
          px_out      <= map_clip_c ? 11'd0 : px_c;
          py_out      <= map_clip_c ? 10'd0 : py_c;
          depth_out   <= map_clip_c ? 32'd0 : ndc_z_q;
        end
        default: ;
      endcase
    end
  end

endmodule
